// File: rtl/mega_fetch.sv
// Instruction prefetch stage for the MEGA CPU: streams ROM words into a 3-entry buffer
// and presents whole 1- or 2-word instructions to the decoder.
module mega_fetch #(
  parameter int unsigned ADDR_ROM_BUS_WIDTH = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [ADDR_ROM_BUS_WIDTH-1:0] rom_a,
  input  logic [15:0]                   rom_d,
  input  logic                          pc_load,
  input  logic [ADDR_ROM_BUS_WIDTH-1:0] pc_new,
  output logic                          ins_ready,
  output logic [15:0]                   ins_w0,
  output logic [15:0]                   ins_w1,
  output logic                          ins_two_word,
  output logic [ADDR_ROM_BUS_WIDTH-1:0] ins_pc,
  input  logic                          ins_take
);

  localparam int unsigned W = ADDR_ROM_BUS_WIDTH;

  logic [W-1:0]       fptr_q, fptr_d;
  logic [W-1:0]       bpc_q, bpc_d;
  logic [2:0][15:0]   wbuf_q, wbuf_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               infl_q, infl_d;

  logic               two_word;
  logic               ready;
  logic               issue;
  logic [1:0]         npop;

  always_comb begin
    two_word = ((wbuf_q[0] & 16'hFC0F) == 16'h9000) || ((wbuf_q[0] & 16'hFE0C) == 16'h940C);
    ready    = two_word ? (cnt_q >= 2'd2) : (cnt_q >= 2'd1);
    npop     = (ins_take && ready) ? (two_word ? 2'd2 : 2'd1) : 2'd0;
    // cnt + infl never exceeds 3, so a push slot is always available when a read lands
    issue    = ({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd3;

    case (npop)
      2'd1:    wbuf_d = {wbuf_q[2], wbuf_q[2:1]};
      2'd2:    wbuf_d = {wbuf_q[2], wbuf_q[2], wbuf_q[2]};
      default: wbuf_d = wbuf_q;
    endcase
    if (infl_q) begin
      wbuf_d[cnt_q - npop] = rom_d;
    end

    cnt_d  = cnt_q - npop + {1'b0, infl_q};
    bpc_d  = bpc_q + W'(npop);
    fptr_d = issue ? fptr_q + W'(1) : fptr_q;
    infl_d = issue;

    // A load discards both the buffer and the word currently on its way from the ROM
    if (pc_load) begin
      cnt_d  = 2'd0;
      infl_d = 1'b0;
      fptr_d = pc_new;
      bpc_d  = pc_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fptr_q <= '0;
      bpc_q  <= '0;
      wbuf_q <= '0;
      cnt_q  <= 2'd0;
      infl_q <= 1'b0;
    end else begin
      fptr_q <= fptr_d;
      bpc_q  <= bpc_d;
      wbuf_q <= wbuf_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
    end
  end

  assign rom_a        = fptr_q;
  assign ins_ready    = ready;
  assign ins_w0       = wbuf_q[0];
  assign ins_w1       = wbuf_q[1];
  assign ins_two_word = two_word;
  assign ins_pc       = bpc_q;

endmodule

// File: tb/tb_mega_fetch.sv
// Bench for mega_fetch: directed latency/boundary cases plus a random run checked against
// an instruction-stream model that walks program memory by instruction length.
module tb_mega_fetch;

  localparam int unsigned W = 14;
  localparam int unsigned MSize = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] rom_a;
  logic [15:0]  rom_d;
  logic         pc_load;
  logic [W-1:0] pc_new;
  logic         ins_ready;
  logic [15:0]  ins_w0;
  logic [15:0]  ins_w1;
  logic         ins_two_word;
  logic [W-1:0] ins_pc;
  logic         ins_take;

  logic [15:0]  mem [MSize];
  int           total = 0;
  int           bad = 0;

  mega_fetch #(.ADDR_ROM_BUS_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_a        (rom_a),
    .rom_d        (rom_d),
    .pc_load      (pc_load),
    .pc_new       (pc_new),
    .ins_ready    (ins_ready),
    .ins_w0       (ins_w0),
    .ins_w1       (ins_w1),
    .ins_two_word (ins_two_word),
    .ins_pc       (ins_pc),
    .ins_take     (ins_take)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM, one cycle read latency
  always @(posedge clk) rom_d <= mem[rom_a];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic is_two(input logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ins_ready && n < 8) begin
      step();
      n++;
    end
    chk(tag, {31'd0, ins_ready}, 32'd1);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
  endtask

  initial begin
    logic [W-1:0] exp_pc;
    logic [15:0]  ew;
    int           gap;

    for (int i = 0; i < int'(MSize); i++) mem[i] = 16'h0000;
    fill_linear();
    rst = 1'b1; pc_load = 1'b0; pc_new = '0; ins_take = 1'b0;

    // T1: reset and first-fetch latency
    step(); step(); step();
    chk("t1_rom_a_rst", 32'(rom_a), 32'd0);
    chk("t1_ready_rst", {31'd0, ins_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("t1_ready_e1", {31'd0, ins_ready}, 32'd0);
    step();
    chk("t1_ready_e2", {31'd0, ins_ready}, 32'd1);
    chk("t1_w0", 32'(ins_w0), 32'h0000);
    chk("t1_pc", 32'(ins_pc), 32'd0);

    // T2: back-to-back single-word instructions
    ins_take = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_ready", {31'd0, ins_ready}, 32'd1);
      chk("t2_pc", 32'(ins_pc), 32'(i));
      step();
    end
    ins_take = 1'b0;

    // T3: two-word JMP followed by NOP
    mem[4] = 16'h940C; mem[5] = 16'h0100; mem[6] = 16'h0000;
    pc_load = 1'b1; pc_new = 14'd4;
    step();
    pc_load = 1'b0;
    wait_ready("t3_wait");
    chk("t3_two", {31'd0, ins_two_word}, 32'd1);
    chk("t3_w0", 32'(ins_w0), 32'h940C);
    chk("t3_w1", 32'(ins_w1), 32'h0100);
    chk("t3_pc", 32'(ins_pc), 32'd4);
    ins_take = 1'b1;
    step();
    ins_take = 1'b0;
    wait_ready("t3_wait2");
    chk("t3_next_pc", 32'(ins_pc), 32'd6);

    // Reset wins over a simultaneous load
    fill_linear();
    rst = 1'b1; pc_load = 1'b1; pc_new = 14'h0123;
    step();
    chk("rst_over_load", 32'(rom_a), 32'd0);
    rst = 1'b0; pc_load = 1'b0;

    // T4: stall saturates the buffer, then resume without gaps
    for (int i = 0; i < 10; i++) step();
    chk("t4_rom_a", 32'(rom_a), 32'd3);
    ins_take = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t4_ready", {31'd0, ins_ready}, 32'd1);
      chk("t4_pc", 32'(ins_pc), 32'(i));
      step();
    end
    ins_take = 1'b0;

    // T5: flush with buffer at 2 words and a read in flight
    mem[14'h0200] = 16'h1234;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); step();
    pc_load = 1'b1; pc_new = 14'h0200;
    step();
    pc_load = 1'b0;
    chk("t5_ready_e0", {31'd0, ins_ready}, 32'd0);
    step();
    chk("t5_ready_e1", {31'd0, ins_ready}, 32'd0);
    step();
    chk("t5_ready_e2", {31'd0, ins_ready}, 32'd1);
    chk("t5_pc", 32'(ins_pc), 32'h0200);
    chk("t5_w0", 32'(ins_w0), 32'h1234);

    // T6: two-word instruction spanning the address wrap
    mem[MSize-1] = 16'h9200; mem[0] = 16'h0060; mem[1] = 16'h0001;
    pc_load = 1'b1; pc_new = 14'h3FFF;
    step();
    pc_load = 1'b0;
    wait_ready("t6_wait");
    chk("t6_two", {31'd0, ins_two_word}, 32'd1);
    chk("t6_pc", 32'(ins_pc), 32'h3FFF);
    chk("t6_w1", 32'(ins_w1), 32'h0060);
    ins_take = 1'b1;
    step();
    ins_take = 1'b0;
    wait_ready("t6_wait2");
    chk("t6_next_pc", 32'(ins_pc), 32'd1);

    // Random program and random decoder behaviour against the stream model
    for (int i = 0; i < int'(MSize); i++) begin
      ew = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ew = 16'h9000 | (ew & 16'h03F0);
        1: ew = 16'h940C | (ew & 16'h01F3);
        default: ;
      endcase
      mem[i] = ew;
    end
    exp_pc = '0;
    gap = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (ins_ready) begin
        if (gap > 0) chk("rnd_latency", {31'd0, gap <= 3}, 32'd1);
        gap = 0;
      end else begin
        gap++;
      end
      if (cyc == 0 || $urandom_range(0, 19) == 0) begin
        pc_load  = 1'b1;
        pc_new   = ($urandom_range(0, 1) == 0) ? W'($urandom)
                                               : W'(14'h3FFC + 14'($urandom_range(0, 3)));
        ins_take = 1'b0;
        exp_pc   = pc_new;
        gap      = 0;
      end else begin
        pc_load  = 1'b0;
        ins_take = ($urandom_range(0, 9) < 7);
        if (ins_take && ins_ready) begin
          ew = mem[exp_pc];
          chk("rnd_pc", 32'(ins_pc), 32'(exp_pc));
          chk("rnd_w0", 32'(ins_w0), 32'(ew));
          chk("rnd_two", {31'd0, ins_two_word}, {31'd0, is_two(ew)});
          if (is_two(ew)) begin
            chk("rnd_w1", 32'(ins_w1), 32'(mem[W'(exp_pc + W'(1))]));
            exp_pc = exp_pc + W'(2);
          end else begin
            exp_pc = exp_pc + W'(1);
          end
        end
      end
      step();
    end
    pc_load = 1'b0;
    ins_take = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
